// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared widths, reset address and fetch FSM state encoding
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam int ILEN_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_t;

endpackage

// File: rtl/jalr_target_gen.sv
// rtl/jalr_target_gen.sv - JALR target: rs1 + imm with bit 0 forced to zero
module jalr_target_gen #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] base_i,
   input  logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] tgt_o
);

   logic [XLEN-1:0] sum;

   // Modular add, then clear the LSB so odd sums land on a halfword boundary
   always_comb begin
      sum   = base_i + imm_i;
      tgt_o = sum & ~XLEN'(1);
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, next-PC select and fetch request handshake
module pc_fetch_ctrl #(
   parameter int XLEN = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            branch_taken_i,
   input  logic [XLEN-1:0] branch_target_i,
   input  logic            jalr_i,
   input  logic [XLEN-1:0] jalr_base_i,
   input  logic [XLEN-1:0] jalr_imm_i,
   output logic            fetch_valid_o,
   input  logic            fetch_ready_i,
   output logic [XLEN-1:0] fetch_addr_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            misaligned_o,
   output logic            halted_o
);

   import riscv_pkg::*;

   localparam logic [XLEN-1:0] STEP = XLEN'(ILEN_BYTES);

   pc_state_t       state_q;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
   logic            pending_q, pending_d;
   logic            misaligned_q;

   logic [XLEN-1:0] jalr_tgt;
   logic [XLEN-1:0] redir_tgt;
   logic            redir;
   logic            redir_bad;
   logic            fetch_valid;
   logic            acc;

   jalr_target_gen #(
      .XLEN (XLEN)
   ) u_jalr_target_gen (
      .base_i (jalr_base_i),
      .imm_i  (jalr_imm_i),
      .tgt_o  (jalr_tgt)
   );

   // Pick the redirect source (JALR beats branch) and flag a misaligned target
   always_comb begin
      redir     = jalr_i | branch_taken_i;
      redir_tgt = jalr_i ? jalr_tgt : branch_target_i;
      redir_bad = redir & redir_tgt[1];
   end

   // Request only in RUN; a stall drops the request in the same cycle
   always_comb begin
      fetch_valid = (state_q == RUN) & ~stall_i;
      acc         = fetch_valid & fetch_ready_i;
   end

   // Next-PC selection: redirects win, a parked redirect retires once the
   // in-flight request is accepted or withdrawn, otherwise advance on accept
   always_comb begin
      pc_d       = pc_q;
      pending_d  = pending_q;
      pend_tgt_d = pend_tgt_q;
      if (state_q == RUN) begin
         if (redir_bad) begin
            pending_d = 1'b0;
         end else if (redir) begin
            if (acc || !fetch_valid) begin
               pc_d      = redir_tgt;
               pending_d = 1'b0;
            end else begin
               pending_d  = 1'b1;
               pend_tgt_d = redir_tgt;
            end
         end else if (pending_q && (acc || !fetch_valid)) begin
            pc_d      = pend_tgt_q;
            pending_d = 1'b0;
         end else if (acc) begin
            pc_d = pc_q + STEP;
         end
      end else begin
         pending_d = 1'b0;
      end
   end

   // Fetch FSM plus PC/pending registers; fault pulse is registered here
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         pending_q    <= 1'b0;
         pend_tgt_q   <= '0;
         misaligned_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         pending_q    <= pending_d;
         pend_tgt_q   <= pend_tgt_d;
         misaligned_q <= 1'b0;
         case (state_q)
            BOOT: state_q <= RUN;
            RUN: begin
               if (redir_bad) begin
                  state_q      <= HALT;
                  misaligned_q <= 1'b1;
               end
            end
            HALT: state_q <= HALT;
            default: state_q <= BOOT;
         endcase
      end
   end

   // Output drive; the PC register is the fetch address
   always_comb begin
      fetch_valid_o = fetch_valid;
      fetch_addr_o  = pc_q;
      pc_plus4_o    = pc_q + STEP;
      misaligned_o  = misaligned_q;
      halted_o      = (state_q == HALT);
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rst_w = 1'b1;
   logic        stall = 1'b0;
   logic        br = 1'b0;
   logic [31:0] br_tgt = '0;
   logic        jalr = 1'b0;
   logic [31:0] jbase = '0;
   logic [31:0] jimm = '0;
   logic        ready = 1'b0;

   logic        valid, mis, halt;
   logic [31:0] addr, plus4;
   logic        w_valid, w_mis, w_halt;
   logic [31:0] w_addr, w_plus4;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
      .clk_i(clk), .rst_i(rst), .stall_i(stall),
      .branch_taken_i(br), .branch_target_i(br_tgt),
      .jalr_i(jalr), .jalr_base_i(jbase), .jalr_imm_i(jimm),
      .fetch_valid_o(valid), .fetch_ready_i(ready),
      .fetch_addr_o(addr), .pc_plus4_o(plus4),
      .misaligned_o(mis), .halted_o(halt)
   );

   pc_fetch_ctrl #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk_i(clk), .rst_i(rst_w), .stall_i(stall),
      .branch_taken_i(br), .branch_target_i(br_tgt),
      .jalr_i(jalr), .jalr_base_i(jbase), .jalr_imm_i(jimm),
      .fetch_valid_o(w_valid), .fetch_ready_i(ready),
      .fetch_addr_o(w_addr), .pc_plus4_o(w_plus4),
      .misaligned_o(w_mis), .halted_o(w_halt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", valid); end
      n_cmp++; if (addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h exp 00000000", addr); end
      n_cmp++; if (halt !== 1'b0 || mis !== 1'b0) begin n_bad++; $display("FAIL reset_flags: got halt=%b mis=%b exp 0 0", halt, mis); end
   endtask

   task automatic test_free_run();
      logic [31:0] exp_a;
      for (int i = 0; i < 5; i++) begin
         step();
         exp_a = 32'(i * 4);
         n_cmp++; if (valid !== 1'b1 || addr !== exp_a) begin n_bad++; $display("FAIL free_run_%0d: got v=%b a=%h exp v=1 a=%h", i, valid, addr, exp_a); end
      end
   endtask

   task automatic test_branch();
      br = 1'b1; br_tgt = 32'h100;
      step();
      br = 1'b0;
      n_cmp++; if (addr !== 32'h100) begin n_bad++; $display("FAIL branch_addr: got %h exp 00000100", addr); end
      n_cmp++; if (plus4 !== 32'h104) begin n_bad++; $display("FAIL branch_plus4: got %h exp 00000104", plus4); end
      step();
      n_cmp++; if (addr !== 32'h104) begin n_bad++; $display("FAIL branch_next: got %h exp 00000104", addr); end
   endtask

   task automatic test_backpressure();
      br = 1'b1; br_tgt = 32'h20;
      step();
      n_cmp++; if (addr !== 32'h20) begin n_bad++; $display("FAIL bp_setup: got %h exp 00000020", addr); end
      ready = 1'b0; br_tgt = 32'h80;
      step();
      br = 1'b0;
      n_cmp++; if (addr !== 32'h20 || valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold1: got a=%h v=%b exp a=00000020 v=1", addr, valid); end
      step();
      n_cmp++; if (addr !== 32'h20) begin n_bad++; $display("FAIL bp_hold2: got %h exp 00000020", addr); end
      ready = 1'b1;
      step();
      n_cmp++; if (addr !== 32'h80) begin n_bad++; $display("FAIL bp_release: got %h exp 00000080", addr); end
      step();
      n_cmp++; if (addr !== 32'h84) begin n_bad++; $display("FAIL bp_after: got %h exp 00000084", addr); end
   endtask

   task automatic test_jalr_aligned();
      jalr = 1'b1; jbase = 32'h203; jimm = 32'h2;
      step();
      jalr = 1'b0;
      n_cmp++; if (addr !== 32'h204 || mis !== 1'b0) begin n_bad++; $display("FAIL jalr_lsb: got a=%h mis=%b exp a=00000204 mis=0", addr, mis); end
   endtask

   task automatic test_stall_collision();
      stall = 1'b1;
      #1;
      n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL stall_comb: got %b exp 0", valid); end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (addr !== 32'h204 || valid !== 1'b0) begin n_bad++; $display("FAIL stall_hold_%0d: got a=%h v=%b exp a=00000204 v=0", i, addr, valid); end
      end
      stall = 1'b0;
      #1;
      n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %b exp 1", valid); end
      jalr = 1'b1; jbase = 32'h400; jimm = 32'h10;
      br = 1'b1; br_tgt = 32'h500;
      step();
      jalr = 1'b0; br = 1'b0;
      n_cmp++; if (addr !== 32'h410) begin n_bad++; $display("FAIL collision: got %h exp 00000410", addr); end
      stall = 1'b1; br = 1'b1; br_tgt = 32'h600;
      step();
      br = 1'b0;
      n_cmp++; if (addr !== 32'h600 || valid !== 1'b0) begin n_bad++; $display("FAIL stall_redirect: got a=%h v=%b exp a=00000600 v=0", addr, valid); end
      stall = 1'b0;
   endtask

   task automatic test_misaligned();
      jalr = 1'b1; jbase = 32'h200; jimm = 32'h2;
      step();
      jalr = 1'b0;
      n_cmp++; if (mis !== 1'b1 || halt !== 1'b1) begin n_bad++; $display("FAIL mis_pulse: got mis=%b halt=%b exp 1 1", mis, halt); end
      n_cmp++; if (valid !== 1'b0 || addr !== 32'h600) begin n_bad++; $display("FAIL mis_hold: got v=%b a=%h exp v=0 a=00000600", valid, addr); end
      step();
      n_cmp++; if (mis !== 1'b0 || halt !== 1'b1) begin n_bad++; $display("FAIL mis_one_shot: got mis=%b halt=%b exp 0 1", mis, halt); end
      br = 1'b1; br_tgt = 32'h700;
      step();
      step();
      br = 1'b0;
      n_cmp++; if (valid !== 1'b0 || addr !== 32'h600 || halt !== 1'b1) begin n_bad++; $display("FAIL halt_sticky: got v=%b a=%h h=%b exp v=0 a=00000600 h=1", valid, addr, halt); end
   endtask

   task automatic test_reset_pending();
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_cmp++; if (halt !== 1'b0 || valid !== 1'b0) begin n_bad++; $display("FAIL rst_from_halt: got h=%b v=%b exp 0 0", halt, valid); end
      step();
      ready = 1'b0; br = 1'b1; br_tgt = 32'h300;
      step();
      br = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      ready = 1'b1;
      step();
      step();
      n_cmp++; if (addr !== 32'h4) begin n_bad++; $display("FAIL rst_drops_pending: got %h exp 00000004", addr); end
   endtask

   task automatic test_wrap();
      ready = 1'b1; stall = 1'b0; br = 1'b0; jalr = 1'b0;
      rst_w = 1'b0;
      #1;
      n_cmp++; if (w_addr !== 32'hFFFF_FFF8 || w_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_boot: got a=%h v=%b exp a=fffffff8 v=0", w_addr, w_valid); end
      step();
      n_cmp++; if (w_addr !== 32'hFFFF_FFF8 || w_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_first: got a=%h v=%b exp a=fffffff8 v=1", w_addr, w_valid); end
      step();
      n_cmp++; if (w_addr !== 32'hFFFF_FFFC || w_plus4 !== 32'h0) begin n_bad++; $display("FAIL wrap_fc: got a=%h p4=%h exp a=fffffffc p4=00000000", w_addr, w_plus4); end
      step();
      n_cmp++; if (w_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_zero: got %h exp 00000000", w_addr); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_branch();
      test_backpressure();
      test_jalr_aligned();
      test_stall_collision();
      test_misaligned();
      test_reset_pending();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
